// File: rtl/cpu_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_arbiter_if
// Description : Signal bundle for the two-port CPU bus arbiter. It carries
//               both requester ports (req/we/addr/wdata in, ack/err/rdata
//               out), the shared downstream bus (strobe/we/addr/data out,
//               data/ready in) and the status outputs (busy/owner).
//               Signal directions in the names are seen from the arbiter.
//   modport slave  : arbiter side (drives o_*, reads i_*)
//   modport master : environment side (drives i_*, reads o_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Requester 0 (CPU core)
  logic              i_req0;
  logic              i_we0;
  logic [ADDR_W-1:0] i_addr0;
  logic [DATA_W-1:0] i_wdata0;
  logic              o_ack0;
  logic              o_err0;
  logic [DATA_W-1:0] o_rdata0;
  // Requester 1 (DMA / video engine)
  logic              i_req1;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_ack1;
  logic              o_err1;
  logic [DATA_W-1:0] o_rdata1;
  // Shared downstream bus
  logic              o_bus_clk;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [DATA_W-1:0] o_bus_data;
  logic [DATA_W-1:0] i_bus_data;
  logic              i_bus_data_ready;
  // Status
  logic              o_busy;
  logic              o_owner;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    input  i_bus_data, i_bus_data_ready,
    output o_ack0, o_err0, o_rdata0,
    output o_ack1, o_err1, o_rdata1,
    output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
    output o_busy, o_owner
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    output i_bus_data, i_bus_data_ready,
    input  o_ack0, o_err0, o_rdata0,
    input  o_ack1, o_err1, o_rdata1,
    input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
    input  o_busy, o_owner
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_arbiter
// Description : Two-port round-robin arbiter and transaction sequencer for
//               the CPU external bus. One transaction at a time walks
//               IDLE -> ISSUE -> WAIT -> DONE. ISSUE strobes the bus for one
//               cycle, WAIT polls the ready handshake (with a timeout), DONE
//               pulses ack/err back to the winning requester.
// Ports       : i_cpu_clk - sole clock, rising edge
//               i_rst     - asynchronous active-high reset
//               arb       - cpu_bus_arbiter_if.slave: requester ports,
//                           downstream bus, busy/owner status
// Parameters  : ADDR_W, DATA_W - address / data widths
//               TIMEOUT        - WAIT cycles before abort (1..65535)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_cpu_clk,
  input  logic                  i_rst,
  cpu_bus_arbiter_if.slave      arb
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Counter value seen in the last WAIT cycle before the timeout fires.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              bus_clk_q, bus_clk_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win_sel;

  // On a tie the port that did not win last time gets the bus; otherwise
  // the single active requester wins.
  assign win_sel = (arb.i_req0 && arb.i_req1) ? ~last_q : arb.i_req1;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    bus_we_d   = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;

    case (state_q)
      ST_IDLE: begin
        if (arb.i_req0 || arb.i_req1) begin
          owner_d    = win_sel;
          last_d     = win_sel;
          bus_we_d   = win_sel ? arb.i_we1    : arb.i_we0;
          bus_addr_d = win_sel ? arb.i_addr1  : arb.i_addr0;
          bus_data_d = win_sel ? arb.i_wdata1 : arb.i_wdata0;
          cnt_d      = 16'd0;
          state_d    = ST_ISSUE;
        end
      end

      // Ready is deliberately not looked at here: a level left over from
      // the previous transaction must not complete this one.
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (arb.i_bus_data_ready) begin
          // Ready beats a same-cycle timeout.
          err_d = 1'b0;
          if (!bus_we_q) begin
            if (owner_q) rdata1_d = arb.i_bus_data;
            else         rdata0_d = arb.i_bus_data;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (!bus_we_q) begin
            if (owner_q) rdata1_d = '0;
            else         rdata0_d = '0;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the FSM occupies that state.
    bus_clk_d = (state_d == ST_ISSUE);
    busy_d    = (state_d != ST_IDLE);
    ack0_d    = (state_d == ST_DONE) && !owner_d;
    ack1_d    = (state_d == ST_DONE) &&  owner_d;
    if (ack0_d) err0_d = err_d;
    if (ack1_d) err1_d = err_d;
  end

  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
      bus_clk_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      busy_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      bus_clk_q  <= bus_clk_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      busy_q     <= busy_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign arb.o_ack0      = ack0_q;
  assign arb.o_ack1      = ack1_q;
  assign arb.o_err0      = err0_q;
  assign arb.o_err1      = err1_q;
  assign arb.o_rdata0    = rdata0_q;
  assign arb.o_rdata1    = rdata1_q;
  assign arb.o_bus_clk   = bus_clk_q;
  assign arb.o_bus_we    = bus_we_q;
  assign arb.o_bus_addr  = bus_addr_q;
  assign arb.o_bus_data  = bus_data_q;
  assign arb.o_busy      = busy_q;
  assign arb.o_owner     = owner_q;

endmodule
`default_nettype wire
